// File: rtl/operational_unit_if.sv
// Micro-word, operand input and result/flag bus between the control unit
// (master) and the operational unit datapath (slave).
interface operational_unit_if #(parameter int WIDTH = 8);
  logic [16:0]      control_bus;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             out_ready;
  logic             overrun;
  logic             carry_flag;
  logic             zero_flag;

  modport master (
    output control_bus, data_in, out_ready,
    input  data_out, out_valid, overrun, carry_flag, zero_flag
  );
  modport slave (
    input  control_bus, data_in, out_ready,
    output data_out, out_valid, overrun, carry_flag, zero_flag
  );
endinterface

// File: rtl/operational_unit.sv
// Datapath driven by a 17-bit micro-word: 4-entry register file, ALU, flags
// and a valid/ready result port. OPUNIT_R0_ZERO_EN makes R0 a constant zero.
module operational_unit #(
  parameter int WIDTH = 8
) (
  input  logic              clock,
  input  logic              reset,
  operational_unit_if.slave bus
);
  typedef struct packed {
    logic [2:0] alu_op;
    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic [1:0] sel_dst;
    logic       write_en;
    logic       flags_en;
    logic       load_in;
    logic       out_en;
    logic       use_imm;
    logic [2:0] imm;
  } uword_t;

`ifdef OPUNIT_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  uword_t                  uw;
  logic [3:0][WIDTH-1:0]   regs;
  logic [WIDTH-1:0]        op_a, op_b, reg_b, alu_res, wr_val, data_q;
  logic [WIDTH:0]          wide;
  logic                    alu_c, nxt_c, nxt_z, wr_ok;
  logic                    valid_q, overrun_q, carry_q, zero_q;

  assign uw = uword_t'(bus.control_bus);

  // Reads are combinational and see the pre-edge register contents.
  always_comb begin
    op_a  = (R0_ZERO && uw.sel_a == 2'd0) ? '0 : regs[uw.sel_a];
    reg_b = (R0_ZERO && uw.sel_b == 2'd0) ? '0 : regs[uw.sel_b];
    op_b  = uw.use_imm ? {{(WIDTH-3){1'b0}}, uw.imm} : reg_b;
  end

  always_comb begin
    wide    = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    unique case (uw.alu_op)
      3'b000: alu_res = op_a;
      3'b001: alu_res = op_b;
      3'b010: begin
        wide    = {1'b0, op_a} + {1'b0, op_b};
        alu_res = wide[WIDTH-1:0];
        alu_c   = wide[WIDTH];
      end
      3'b011: begin
        // MSB of the widened difference is the unsigned borrow
        wide    = {1'b0, op_a} - {1'b0, op_b};
        alu_res = wide[WIDTH-1:0];
        alu_c   = wide[WIDTH];
      end
      3'b100: alu_res = op_a & op_b;
      3'b101: alu_res = op_a | op_b;
      3'b110: alu_res = op_a ^ op_b;
      3'b111: begin
        alu_res = {op_a[WIDTH-2:0], 1'b0};
        alu_c   = op_a[WIDTH-1];
      end
      default: ;
    endcase
  end

  always_comb begin
    wr_val = uw.load_in ? bus.data_in : alu_res;
    nxt_c  = uw.load_in ? 1'b0 : alu_c;
    nxt_z  = uw.load_in ? (bus.data_in == '0) : (alu_res == '0);
    wr_ok  = uw.write_en && !(R0_ZERO && uw.sel_dst == 2'd0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      regs <= '0;
    end else if (wr_ok) begin
      regs[uw.sel_dst] <= wr_val;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else if (uw.flags_en) begin
      carry_q <= nxt_c;
      zero_q  <= nxt_z;
    end
  end

  // A new result always lands; overwriting one nobody took is flagged sticky.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else if (uw.out_en) begin
      data_q  <= op_a;
      valid_q <= 1'b1;
      if (valid_q && !bus.out_ready) overrun_q <= 1'b1;
    end else if (valid_q && bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.out_valid  = valid_q;
  assign bus.overrun    = overrun_q;
  assign bus.carry_flag = carry_q;
  assign bus.zero_flag  = zero_q;
endmodule
